// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: bubble encoding,
// reset PC, fetch FSM states, PC-source select and word-alignment helpers.
package pipeline_pkg;

    localparam logic [31:0] NOP_INST        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ    = 2'b00,
        BRANCH = 2'b01,
        JUMP   = 2'b10,
        HOLD   = 2'b11
    } redirect_sel_e;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings (ROM, ID stage, hazard unit).
// The master side is the fetch stage. Optional perf outputs appear only when
// IF_FETCH_PERF_EN is defined.
interface if_fetch_stage_if;

    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCplus4;
    logic        ID_Valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] PerfFetched;
    logic [31:0] PerfBubbles;

    modport master (
        output Addr, ID_Inst, ID_PC, ID_PCplus4, ID_Valid, PerfFetched, PerfBubbles,
        input  Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );
    modport slave (
        input  Addr, ID_Inst, ID_PC, ID_PCplus4, ID_Valid, PerfFetched, PerfBubbles,
        output Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );
`else
    modport master (
        output Addr, ID_Inst, ID_PC, ID_PCplus4, ID_Valid,
        input  Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );
    modport slave (
        input  Addr, ID_Inst, ID_PC, ID_PCplus4, ID_Valid,
        output Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );
`endif

endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Hold beats bubble beats load; a bubble replaces the
// instruction with NOP and clears valid while keeping the PC fields.
module ifid_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        hold,
    input  logic        bubble,
    input  logic        load,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    logic [31:0] inst_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic        valid_r;

    // IF/ID register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            inst_r     <= NOP_INST;
            pc_r       <= 32'h0000_0000;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (hold) begin
            inst_r     <= inst_r;
            pc_r       <= pc_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end else if (bubble) begin
            inst_r     <= NOP_INST;
            valid_r    <= 1'b0;
        end else if (load) begin
            inst_r     <= inst;
            pc_r       <= pc;
            pc_plus4_r <= pc_plus4;
            valid_r    <= 1'b1;
        end else begin
            valid_r    <= valid_r;
        end
    end

    assign id_inst     = inst_r;
    assign id_pc       = pc_r;
    assign id_pc_plus4 = pc_plus4_r;
    assign id_valid    = valid_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the
// IF/ID register. Redirects from ID insert one bubble; Stall freezes everything.
// Optional feature macro: IF_FETCH_PERF_EN adds saturating fetch/bubble counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = pipeline_pkg::NOP_INST
) (
    input  logic            Clk,
    input  logic            Clrn,
    if_fetch_stage_if.master bus
);
    import pipeline_pkg::*;

    logic [31:0]   pc_r;
    logic [31:0]   pc_next_s;
    logic [31:0]   pc_plus4_s;
    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    redirect_sel_e sel_s;
    logic          load_s;
    logic          bubble_s;
    logic          hold_s;
    logic [31:0]   id_inst_s;
    logic [31:0]   id_pc_s;
    logic [31:0]   id_pc_plus4_s;
    logic          id_valid_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign bus.Addr   = pc_r;

    // PC source priority: Stall, then Jump, then branch; a bubble in ID never redirects.
    always_comb begin
        sel_s = SEQ;
        if (bus.Stall) begin
            sel_s = HOLD;
        end else if (id_valid_s && bus.Jump) begin
            sel_s = JUMP;
        end else if (id_valid_s && bus.BranchTaken) begin
            sel_s = BRANCH;
        end else begin
            sel_s = SEQ;
        end
    end

    // Next-PC mux and IF/ID control decode.
    always_comb begin
        pc_next_s = pc_plus4_s;
        load_s    = 1'b0;
        bubble_s  = 1'b0;
        hold_s    = 1'b0;
        case (sel_s)
            HOLD: begin
                pc_next_s = pc_r;
                hold_s    = 1'b1;
            end
            JUMP: begin
                pc_next_s = align_word(bus.JumpTarget);
                bubble_s  = 1'b1;
            end
            BRANCH: begin
                pc_next_s = align_word(bus.BranchTarget);
                bubble_s  = 1'b1;
            end
            SEQ: begin
                pc_next_s = pc_plus4_s;
                load_s    = 1'b1;
            end
            default: begin
                pc_next_s = pc_r;
                hold_s    = 1'b1;
            end
        endcase
    end

    // PC register.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Redirect FSM next state: one FLUSH cycle per redirect, stretched by Stall.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (bubble_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = FETCH;
                end
            end
            FLUSH: begin
                if (bus.Stall) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = FETCH;
                end
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // Redirect FSM state register.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk         (Clk),
        .clrn        (Clrn),
        .hold        (hold_s),
        .bubble      (bubble_s),
        .load        (load_s),
        .inst        (bus.Inst),
        .pc          (pc_r),
        .pc_plus4    (pc_plus4_s),
        .id_inst     (id_inst_s),
        .id_pc       (id_pc_s),
        .id_pc_plus4 (id_pc_plus4_s),
        .id_valid    (id_valid_s)
    );

    assign bus.ID_Inst    = id_inst_s;
    assign bus.ID_PC      = id_pc_s;
    assign bus.ID_PCplus4 = id_pc_plus4_s;
    assign bus.ID_Valid   = id_valid_s;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_bubbles_r;

    // Saturating counters: real fetches, and edges that bubble or hold.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_bubbles_r <= 32'h0000_0000;
        end else begin
            if (load_s) begin
                perf_fetched_r <= sat_inc(perf_fetched_r);
            end
            if (bubble_s || hold_s) begin
                perf_bubbles_r <= sat_inc(perf_bubbles_r);
            end
        end
    end

    assign bus.PerfFetched = perf_fetched_r;
    assign bus.PerfBubbles = perf_bubbles_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a small ROM model answers Addr, each step
// pushes its expected IF/ID and PC state to a scoreboard, then pops and checks
// it one edge later.
module tb_if_fetch_stage;
    import pipeline_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  inst;
        logic [31:0]  pc;
        logic [31:0]  pc4;
        logic         valid;
        fetch_state_e st;
    } exp_t;

    logic Clk;
    logic Clrn;
    int   vectors;
    int   miscompares;
    int   exp_fetched;
    int   exp_bubbles;
    exp_t sb_q[$];

    if_fetch_stage_if bus();

    if_fetch_stage dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_f = 32'h2001_0008;
            32'h0000_0004: rom_f = 32'h3402_000C;
            32'h0000_0030: rom_f = 32'hAD02_000A;
            default:       rom_f = a ^ 32'h8C00_0000;
        endcase
    endfunction

    // Combinational ROM answering the current fetch address.
    always_comb begin
        bus.Inst = rom_f(bus.Addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rstn, input logic stall,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic [31:0] e_addr, input logic [31:0] e_inst,
                        input logic [31:0] e_pc, input logic [31:0] e_pc4,
                        input logic e_valid, input fetch_state_e e_st);
        exp_t e;
        Clrn             = rstn;
        bus.Stall        = stall;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = j;
        bus.JumpTarget   = jt;
        e.addr  = e_addr;
        e.inst  = e_inst;
        e.pc    = e_pc;
        e.pc4   = e_pc4;
        e.valid = e_valid;
        e.st    = e_st;
        sb_q.push_back(e);
        if (!rstn) begin
            exp_fetched = 0;
            exp_bubbles = 0;
        end else if (stall || !e_valid) begin
            exp_bubbles++;
        end else begin
            exp_fetched++;
        end
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "/Addr"},       bus.Addr,                 e.addr);
        chk({tag, "/ID_Inst"},    bus.ID_Inst,              e.inst);
        chk({tag, "/ID_PC"},      bus.ID_PC,                e.pc);
        chk({tag, "/ID_PCplus4"}, bus.ID_PCplus4,           e.pc4);
        chk({tag, "/ID_Valid"},   {31'd0, bus.ID_Valid},    {31'd0, e.valid});
        chk({tag, "/state"},      {31'd0, dut.state_r},     {31'd0, e.st});
`ifdef IF_FETCH_PERF_EN
        chk({tag, "/PerfFetched"}, bus.PerfFetched, 32'(exp_fetched));
        chk({tag, "/PerfBubbles"}, bus.PerfBubbles, 32'(exp_bubbles));
`endif
    endtask

    initial begin
        Clk              = 1'b0;
        Clrn             = 1'b0;
        vectors          = 0;
        miscompares      = 0;
        exp_fetched      = 0;
        exp_bubbles      = 0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'h0000_0000;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = 32'h0000_0000;

        // Reset state
        step("rst0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0, FETCH);
        step("rst1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0, FETCH);

        // Sequential fetch from reset up to PC=0x20
        step("seq0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h4, 32'h2001_0008, 32'h0, 32'h4, 1'b1, FETCH);
        step("seq1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h8, 32'h3402_000C, 32'h4, 32'h8, 1'b1, FETCH);
        for (int k = 2; k < 8; k++) begin
            step("seqn", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'(k * 4 + 4), rom_f(32'(k * 4)), 32'(k * 4), 32'(k * 4 + 4), 1'b1, FETCH);
        end

        // Taken branch at PC=0x20 to 0x30
        step("br", 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0,
             32'h30, 32'h0, 32'h1C, 32'h20, 1'b0, FLUSH);
        step("br_tgt", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h34, 32'hAD02_000A, 32'h30, 32'h34, 1'b1, FETCH);

        // Stall at PC=0x34 for three edges with a branch pending
        for (int k = 0; k < 3; k++) begin
            step("stall", 1'b1, 1'b1, 1'b1, 32'h50, 1'b0, 32'h0,
                 32'h34, 32'hAD02_000A, 32'h30, 32'h34, 1'b1, FETCH);
        end
        step("br_after_stall", 1'b1, 1'b0, 1'b1, 32'h50, 1'b0, 32'h0,
             32'h50, 32'h0, 32'h30, 32'h34, 1'b0, FLUSH);
        step("br2_tgt", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h54, rom_f(32'h50), 32'h50, 32'h54, 1'b1, FETCH);

        // Jump and branch together: jump wins
        step("jmp_br", 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 32'h0,
             32'h0, 32'h0, 32'h50, 32'h54, 1'b0, FLUSH);
        // Branch held high while ID holds a bubble is ignored
        step("br_on_bubble", 1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0,
             32'h4, 32'h2001_0008, 32'h0, 32'h4, 1'b1, FETCH);

        // Unaligned jump target near the top of memory, stall in FLUSH, then wrap
        step("jmp_top", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE,
             32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4, 1'b0, FLUSH);
        step("flush_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
             32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4, 1'b0, FLUSH);
        step("wrap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h0, rom_f(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1, FETCH);

        // Jump to 0x48 (unaligned target), then reset while in FLUSH
        step("jmp_48", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_004B,
             32'h48, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, FLUSH);
        step("rst_mid", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0, FETCH);
        step("post_rst", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
             32'h4, 32'h2001_0008, 32'h0, 32'h4, 1'b1, FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: the reader side of the instruction ROM.
- Owns the PC, drives the ROM address, and captures the returned instruction into the IF/ID pipeline register.
- Handles ID-resolved branch/jump redirects with a one-bubble flush, and load-use stalls.
- Sits between the ROM and the ID stage/hazard unit.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000000, encoding injected into IF/ID for bubbles (sll $0,$0,0).

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Clrn  input  1  synchronous active-low reset, sampled on rising Clk.
- Addr  output  32  ROM byte address; equals PC combinationally.
- Inst  input  32  ROM read data for Addr; combinational, valid in the same cycle.
- Stall  input  1  hazard unit: hold PC and IF/ID.
- BranchTaken  input  1  ID stage: conditional branch resolved taken.
- BranchTarget  input  32  ID stage: branch destination byte address.
- Jump  input  1  ID stage: unconditional jump.
- JumpTarget  input  32  ID stage: jump destination byte address.
- ID_Inst  output  32  IF/ID instruction.
- ID_PC  output  32  IF/ID address of ID_Inst.
- ID_PCplus4  output  32  IF/ID ID_PC+4.
- ID_Valid  output  1  1 when ID_Inst is a real fetched instruction, 0 for a bubble.

Behaviour:
- Reset (Clrn=0 at edge, mid-operation included):
  - PC=RESET_PC.
  - ID_Inst=NOP_INST, ID_PC=0, ID_PCplus4=0, ID_Valid=0.
  - Overrides every other input.
- Addr=PC at all times. Low two bits of every loaded target are forced to 0, so PC is always word-aligned.
- Latency: an instruction at address A appears on ID_Inst one edge after the cycle in which PC=A.
- Priority per edge (highest first): reset, Stall, Jump, BranchTaken, sequential.
  - Stall=1: PC and all ID_* hold. Jump/BranchTaken are ignored, because the stalled ID instruction re-presents them next cycle.
  - Jump=1: PC<=JumpTarget&~3. IF/ID<=bubble (ID_Inst=NOP_INST, ID_Valid=0, ID_PC/ID_PCplus4 hold previous values).
  - BranchTaken=1 (Jump=0): PC<=BranchTarget&~3; IF/ID<=bubble.
  - Otherwise: PC<=PC+4; ID_Inst<=Inst, ID_PC<=PC, ID_PCplus4<=PC+4, ID_Valid<=1.
- Jump and BranchTaken both high: Jump wins.
- Arithmetic: PC+4 is 32-bit modulo, so 0xFFFFFFFC wraps to 0x00000000 with no flag.
- Redirect-state FSM (FETCH/FLUSH):
  - Redirect in FETCH -> FLUSH for exactly one cycle, during which the bubble sits in ID.
  - FLUSH -> FETCH unconditionally unless Stall=1, in which case it holds FLUSH.
  - A second redirect while in FLUSH is legal only if ID_Valid=0; the block ignores redirects when ID_Valid=0, since a bubble cannot branch.
  - FSM state is exposed to the perf logic only.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, the block adds outputs PerfFetched[31:0] and PerfBubbles[31:0].
  - PerfFetched counts edges with ID_Valid<=1.
  - PerfBubbles counts edges injecting a bubble or holding on Stall.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg): NOP_INST, RESET_PC, the fetch FSM state enum (FETCH, FLUSH), the redirect-select enum (SEQ, BRANCH, JUMP, HOLD), and WORD_ALIGN_MASK=32'hFFFFFFFC.
- One sub-module, ifid_reg: the IF/ID register with hold/bubble/load controls and reset. The PC mux and FSM stay in the top.

Test Plan:
- Reset release with ROM program: first edge gives ID_Inst=32'h20010008, ID_PC=0, ID_PCplus4=4, ID_Valid=1. Next edge gives ID_Inst=32'h3402000C.
- Taken branch: with PC=0x20, BranchTaken=1 and BranchTarget=0x30 for one cycle. Next cycle Addr=0x30, ID_Valid=0, ID_Inst=0. The following edge gives ID_Inst=32'hAD02000A, ID_PC=0x30.
- Jump plus branch together: Jump=1/JumpTarget=0x0 and BranchTaken=1/BranchTarget=0x30 in the same cycle. Addr=0x0 next cycle, one bubble, then ID_Inst=32'h20010008.
- Stall: Stall=1 for 3 cycles at PC=0x34 with BranchTaken=1 asserted. Addr stays 0x34 and ID_* are unchanged throughout. After Stall drops and the branch is reasserted, the redirect takes effect.
- Wrap and alignment: JumpTarget=0xFFFFFFFE gives Addr=0xFFFFFFFC. The next edge gives Addr=0x00000000 and ID_PC=0xFFFFFFFC.
- Reset mid-run: Clrn=0 for one edge while in FLUSH at PC=0x48 gives Addr=0, ID_Valid=0, FSM=FETCH. With IF_FETCH_PERF_EN defined, both counters read 0.
